ddr3_lane_read_eye_trainer: RTL and testbench

Per-lane read-eye training controller for the DDR3 PHY byte lanes. It sequences the input delay line and eye monitor of one lane's read-training IOD on the fabric clock. It sweeps the delay taps, finds the widest contiguous window of clean taps, and parks the delay line at the window centre. One instance sits beside each lane's read-training IOD and is started by the PHY training sequencer.

---
 rtl/ddr3_rdtrain_pkg.sv | 27 ++
 rtl/ddr3_rdtrain_dwell_timer.sv | 26 ++
 rtl/ddr3_lane_read_eye_trainer.sv | 193 +++++++++++++++++++
 tb/tb_ddr3_lane_read_eye_trainer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ddr3_rdtrain_pkg.sv
// Shared types and helpers for the per-lane DDR3 read-eye trainer.
package ddr3_rdtrain_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CLEAR,
        ST_SETTLE,
        ST_SAMPLE,
        ST_STEP,
        ST_GAP,
        ST_CTR_SETUP,
        ST_CTR_MOVE,
        ST_CTR_GAP,
        ST_FINISH
    } state_t;

    // Width, in cycles, of every delay-line and eye-monitor strobe.
    localparam int STROBE_W = 1;

    // Window centre, floored; evaluated wide so start+len/2 cannot wrap.
    function automatic logic [31:0] rdtrain_centre(input logic [31:0] win_start,
                                                    input logic [31:0] win_len);
        return win_start + (win_len >> 1);
    endfunction

endpackage

// File: rtl/ddr3_rdtrain_dwell_timer.sv
// Loadable down-counter timing the SETTLE and SAMPLE dwell periods.
module ddr3_rdtrain_dwell_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/ddr3_lane_read_eye_trainer.sv
// Sweeps one lane's read delay line, tracks the widest clean tap window and
// parks the line at its centre. start is a one-cycle request taken only in IDLE.
module ddr3_lane_read_eye_trainer
    import ddr3_rdtrain_pkg::*;
#(
    parameter int TAP_W      = 8,
    parameter int MAX_TAPS   = 128,
    parameter int SETTLE_CYC = 8,
    parameter int SAMPLE_CYC = 16,
    parameter int MIN_WINDOW = 4
) (
    input  logic             FAB_CLK,
    input  logic             ARST_N,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [TAP_W-1:0] center_tap,
    output logic [TAP_W-1:0] window_width,
    output logic             dl_load,
    output logic             dl_move,
    output logic             dl_direction,
    input  logic             dl_out_of_range,
    output logic             em_clear_flags,
    input  logic             em_early,
    input  logic             em_late,
    output state_t           state_dbg
);

    localparam int CNT_W = 16;
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(MAX_TAPS - 1);

    state_t           state;
    logic [TAP_W-1:0] cur_tap, target;
    logic [TAP_W-1:0] run_start, best_start;
    logic [TAP_W:0]   run_len, best_len;
    logic             tap_bad, oor, fail_flag;

    logic             tmr_load, tmr_zero;
    logic [CNT_W-1:0] tmr_val;

    logic             bad_now, oor_now, win_ok;
    logic [TAP_W:0]   run_len_nx;
    logic [TAP_W-1:0] run_start_nx, target_nx;

    assign tmr_load = (state == ST_CLEAR) || (state == ST_SETTLE && tmr_zero);
    assign tmr_val  = (state == ST_CLEAR) ? CNT_W'(SETTLE_CYC - 1) : CNT_W'(SAMPLE_CYC - 1);

    ddr3_rdtrain_dwell_timer #(.CNT_W(CNT_W)) u_dwell (
        .clk      (FAB_CLK),
        .rst_n    (ARST_N),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Flags from the final SAMPLE cycle are folded in before the tap is judged.
    assign bad_now      = tap_bad | em_early | em_late;
    assign oor_now      = oor | dl_out_of_range;
    assign run_len_nx   = bad_now ? '0 : run_len + 1'b1;
    assign run_start_nx = (!bad_now && run_len == '0) ? cur_tap : run_start;
    assign win_ok       = (best_len >= (TAP_W+1)'(MIN_WINDOW));
    assign target_nx    = win_ok ? TAP_W'(rdtrain_centre(32'(best_start), 32'(best_len))) : '0;
    assign state_dbg    = state;

    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state          <= ST_IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            fail           <= 1'b0;
            center_tap     <= '0;
            window_width   <= '0;
            dl_load        <= 1'b0;
            dl_move        <= 1'b0;
            dl_direction   <= 1'b1;
            em_clear_flags <= 1'b0;
            cur_tap        <= '0;
            target         <= '0;
            run_start      <= '0;
            best_start     <= '0;
            run_len        <= '0;
            best_len       <= '0;
            tap_bad        <= 1'b0;
            oor            <= 1'b0;
            fail_flag      <= 1'b0;
        end else begin
            // Strobes are raised on the transition into their state, so each
            // is high exactly for the one cycle the FSM spends there.
            dl_load        <= 1'b0;
            dl_move        <= 1'b0;
            em_clear_flags <= 1'b0;
            done           <= 1'b0;
            fail           <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state        <= ST_LOAD;
                        busy         <= 1'b1;
                        dl_load      <= 1'b1;
                        dl_direction <= 1'b1;
                        cur_tap      <= '0;
                        target       <= '0;
                        run_start    <= '0;
                        best_start   <= '0;
                        run_len      <= '0;
                        best_len     <= '0;
                        fail_flag    <= 1'b0;
                        center_tap   <= '0;
                        window_width <= '0;
                    end
                end
                ST_LOAD, ST_GAP: begin
                    state          <= ST_CLEAR;
                    em_clear_flags <= 1'b1;
                    tap_bad        <= 1'b0;
                    oor            <= 1'b0;
                end
                ST_CLEAR: state <= ST_SETTLE;
                ST_SETTLE: begin
                    if (tmr_zero) state <= ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    if (em_early || em_late) tap_bad <= 1'b1;
                    if (dl_out_of_range)     oor     <= 1'b1;
                    if (tmr_zero) begin
                        if (oor_now) begin
                            state        <= ST_CTR_SETUP;
                            dl_direction <= 1'b0;
                        end else begin
                            run_len   <= run_len_nx;
                            run_start <= run_start_nx;
                            // Strict compare keeps the earliest of equal-width windows.
                            if (run_len_nx > best_len) begin
                                best_len   <= run_len_nx;
                                best_start <= run_start_nx;
                            end
                            if (cur_tap == LAST_TAP) begin
                                state        <= ST_CTR_SETUP;
                                dl_direction <= 1'b0;
                            end else begin
                                state   <= ST_STEP;
                                dl_move <= 1'b1;
                            end
                        end
                    end
                end
                ST_STEP: begin
                    state   <= ST_GAP;
                    cur_tap <= cur_tap + 1'b1;
                end
                ST_CTR_SETUP: begin
                    target    <= target_nx;
                    fail_flag <= !win_ok;
                    if (cur_tap == target_nx) begin
                        state        <= ST_FINISH;
                        done         <= 1'b1;
                        fail         <= !win_ok;
                        center_tap   <= target_nx;
                        window_width <= win_ok ? TAP_W'(best_len) : '0;
                        dl_direction <= 1'b1;
                    end else begin
                        state   <= ST_CTR_MOVE;
                        dl_move <= 1'b1;
                    end
                end
                ST_CTR_MOVE: begin
                    state   <= ST_CTR_GAP;
                    cur_tap <= cur_tap - 1'b1;
                end
                ST_CTR_GAP: begin
                    if (cur_tap == target) begin
                        state        <= ST_FINISH;
                        done         <= 1'b1;
                        fail         <= fail_flag;
                        center_tap   <= target;
                        window_width <= fail_flag ? '0 : TAP_W'(best_len);
                        dl_direction <= 1'b1;
                    end else begin
                        state   <= ST_CTR_MOVE;
                        dl_move <= 1'b1;
                    end
                end
                ST_FINISH: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr3_lane_read_eye_trainer.sv
// Directed bench: a delay-line/eye model driven by the trainer's strobes,
// with hand-computed windows, centres, strobe counts and latencies.
module tb_ddr3_lane_read_eye_trainer;
    import ddr3_rdtrain_pkg::*;

    logic       FAB_CLK = 1'b0;
    logic       ARST_N;
    logic       start;
    logic       busy, done, fail;
    logic [7:0] center_tap, window_width;
    logic       dl_load, dl_move, dl_direction;
    logic       dl_out_of_range = 1'b0;
    logic       em_clear_flags;
    logic       em_early = 1'b0;
    logic       em_late = 1'b0;
    state_t     state_dbg;

    ddr3_lane_read_eye_trainer dut (
        .FAB_CLK         (FAB_CLK),
        .ARST_N          (ARST_N),
        .start           (start),
        .busy            (busy),
        .done            (done),
        .fail            (fail),
        .center_tap      (center_tap),
        .window_width    (window_width),
        .dl_load         (dl_load),
        .dl_move         (dl_move),
        .dl_direction    (dl_direction),
        .dl_out_of_range (dl_out_of_range),
        .em_clear_flags  (em_clear_flags),
        .em_early        (em_early),
        .em_late         (em_late),
        .state_dbg       (state_dbg)
    );

    always #5 FAB_CLK = ~FAB_CLK;

    int total = 0;
    int bad   = 0;

    bit [255:0] clean_map;
    bit         oor_enable, early_mode, glitch;
    int         oor_tap;
    int         model_tap = 0;
    int         up_moves, down_moves, loads, done_cnt, viol, strobe_cnt;
    bit         seen_strobe, first_load, prev_dir = 1'b1, prev_move;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit [255:0] win(input int lo, input int hi);
        bit [255:0] m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Delay-line and eye-monitor model, plus strobe bookkeeping.
    always @(negedge FAB_CLK) begin
        bit tap_is_bad;
        if (dl_load) model_tap = 0;
        else if (dl_move) model_tap = dl_direction ? model_tap + 1 : model_tap - 1;
        if (dl_load) loads++;
        if (dl_move && dl_direction) up_moves++;
        if (dl_move && !dl_direction) down_moves++;
        if (done) done_cnt++;
        if (dl_load || dl_move || em_clear_flags) strobe_cnt++;
        if (dl_move && dl_direction != prev_dir) viol++;
        if (prev_move && dl_direction != prev_dir) viol++;
        if (!seen_strobe && (dl_load || dl_move)) begin
            seen_strobe = 1'b1;
            first_load  = dl_load;
        end
        prev_dir  = dl_direction;
        prev_move = dl_move;
        tap_is_bad = (model_tap < 0 || model_tap > 255) ? 1'b1 : !clean_map[model_tap];
        em_late  = tap_is_bad && !early_mode;
        em_early = (tap_is_bad && early_mode) || (glitch && (dl_load || dl_move || em_clear_flags));
        dl_out_of_range = oor_enable && (model_tap >= oor_tap);
    end

    task automatic clear_counts();
        up_moves = 0; down_moves = 0; loads = 0; done_cnt = 0;
        viol = 0; strobe_cnt = 0; seen_strobe = 1'b0; first_load = 1'b0;
    endtask

    task automatic run_case(input string tag, input bit [255:0] map, input bit oor_en,
                            input int oor_at, input bit early, input bit glt, input bit poke,
                            input bit exp_fail, input int exp_ctr, input int exp_w,
                            input int exp_up, input int exp_down);
        int cyc;
        int ntaps;
        int exp_lat;
        clean_map = map; oor_enable = oor_en; oor_tap = oor_at;
        early_mode = early; glitch = glt;
        clear_counts();
        ntaps   = exp_up + 1;
        exp_lat = 1 + 25 * ntaps + 2 * (ntaps - 1) + 1 + 2 * exp_down + 1;
        @(negedge FAB_CLK);
        check({tag, " idle_busy"}, busy, 0);
        start = 1'b1;
        @(negedge FAB_CLK);
        start = 1'b0;
        cyc = 1;
        check({tag, " busy_after_start"}, busy, 1);
        while (done !== 1'b1 && cyc < 8000) begin
            start = poke && (cyc == 50);
            @(negedge FAB_CLK);
            cyc++;
        end
        if (cyc >= 8000) check({tag, " timeout"}, 0, 1);
        check({tag, " latency"}, cyc, exp_lat);
        check({tag, " fail"}, fail, exp_fail);
        check({tag, " center_tap"}, center_tap, exp_ctr);
        check({tag, " window_width"}, window_width, exp_w);
        check({tag, " busy_at_done"}, busy, 1);
        start = poke;
        @(negedge FAB_CLK);
        start = 1'b0;
        check({tag, " busy_after_done"}, busy, 0);
        check({tag, " done_one_cycle"}, done, 0);
        repeat (4) @(negedge FAB_CLK);
        check({tag, " still_idle"}, busy, 0);
        check({tag, " done_count"}, done_cnt, 1);
        check({tag, " load_count"}, loads, 1);
        check({tag, " first_strobe_load"}, first_load, 1);
        check({tag, " up_moves"}, up_moves, exp_up);
        check({tag, " down_moves"}, down_moves, exp_down);
        check({tag, " parked_tap"}, model_tap, exp_ctr);
        check({tag, " dir_vs_move"}, viol, 0);
        check({tag, " held_center"}, center_tap, exp_ctr);
        check({tag, " held_width"}, window_width, exp_w);
    endtask

    initial begin
        int cyc;
        int strobes_before;
        ARST_N = 1'b0;
        start  = 1'b0;
        clean_map = '0; oor_enable = 1'b0; oor_tap = 0; early_mode = 1'b0; glitch = 1'b0;
        clear_counts();
        repeat (3) @(negedge FAB_CLK);
        check("reset_ctrl", {busy, done, fail, dl_load, dl_move, em_clear_flags, dl_direction}, 7'b0000001);
        check("reset_center", center_tap, 0);
        check("reset_width", window_width, 0);
        ARST_N = 1'b1;
        repeat (2) @(negedge FAB_CLK);

        run_case("wide",     win(20, 59),              0, 0,  0, 0, 0, 0, 40,  40, 127, 87);
        run_case("tie",      win(10, 15) | win(30, 35), 0, 0, 1, 0, 0, 0, 13,  6,  127, 114);
        run_case("oor",      win(45, 49),              1, 50, 0, 0, 0, 0, 47,  5,  50,  3);
        run_case("none",     '0,                       0, 0,  0, 0, 0, 1, 0,   0,  127, 127);
        run_case("short",    win(5, 7) | win(40, 42),  0, 0,  0, 0, 0, 1, 0,   0,  127, 127);
        run_case("min_win",  win(100, 103),            0, 0,  0, 1, 0, 0, 102, 4,  127, 25);
        run_case("open_end", win(120, 127),            0, 0,  0, 0, 1, 0, 124, 8,  127, 3);

        // Asynchronous reset while sampling tap 30.
        clean_map = win(20, 59); oor_enable = 1'b0; early_mode = 1'b0; glitch = 1'b0;
        clear_counts();
        start = 1'b1;
        @(negedge FAB_CLK);
        start = 1'b0;
        cyc = 0;
        while (!(state_dbg == ST_SAMPLE && model_tap == 30) && cyc < 3000) begin
            @(negedge FAB_CLK);
            cyc++;
        end
        if (cyc >= 3000) check("mid_reset reach_tap30", 0, 1);
        ARST_N = 1'b0;
        #1;
        check("mid_reset ctrl", {busy, done, fail, dl_load, dl_move, em_clear_flags, dl_direction}, 7'b0000001);
        check("mid_reset center", center_tap, 0);
        check("mid_reset width", window_width, 0);
        strobes_before = strobe_cnt;
        repeat (3) @(negedge FAB_CLK);
        check("mid_reset no_strobes", strobe_cnt - strobes_before, 0);
        check("mid_reset line_kept", model_tap, 30);
        ARST_N = 1'b1;
        repeat (2) @(negedge FAB_CLK);
        run_case("after_reset", win(20, 59), 0, 0, 0, 0, 0, 0, 40, 40, 127, 87);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
